// File: rtl/life_array_sequencer_if.sv
// Host-side command, load-stream and dump-stream signals of the life array sequencer.
// The host drives the master modport and the sequencer sits on the slave modport.
interface life_array_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
);
  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [GEN_W-1:0] cmd_gens;

  // Load stream
  logic [WIDTH-1:0] ld_data;
  logic             ld_valid;
  logic             ld_ready;

  // Dump stream
  logic [WIDTH-1:0] rd_data;
  logic [3:0]       rd_row;
  logic             rd_valid;
  logic             rd_ready;

  // Status
  logic             done;
  logic             cmd_err;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_gens, ld_data, ld_valid, rd_ready,
    input  cmd_ready, ld_ready, rd_data, rd_row, rd_valid, done, cmd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_gens, ld_data, ld_valid, rd_ready,
    output cmd_ready, ld_ready, rd_data, rd_row, rd_valid, done, cmd_err, busy
  );
endinterface

// File: rtl/life_array_sequencer.sv
// Command sequencer for a 16x16 life array tile: LOAD rows, RUN N generations, DUMP rows.
// It is the only driver of the array's control inputs, and every array-side output is registered.
module life_array_sequencer #(
  parameter int ROWS  = 16,
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  life_array_sequencer_if.slave host,
  output logic [WIDTH-1:0]      arr_vali,
  output logic [3:0]            arr_vali_selector,
  output logic                  arr_write_enb,
  output logic                  arr_step,
  output logic [3:0]            arr_valo_selector,
  input  logic [WIDTH-1:0]      arr_valo
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_RUN_GAP, S_RD_ADDR, S_RD_WAIT, S_RD_HOLD, S_FIN
  } state_e;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_e           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [GEN_W-1:0] gen_q;
  logic             err_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] arr_vali_q;
  logic [3:0]       arr_vali_selector_q, arr_valo_selector_q;
  logic             arr_write_enb_q, arr_step_q;
  logic             cmd_fire, ld_fire, rd_fire;

  assign cmd_fire = host.cmd_valid & host.cmd_ready;
  assign ld_fire  = host.ld_valid  & host.ld_ready;
  assign rd_fire  = host.rd_valid  & host.rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/row_d; a missing branch would infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (cmd_fire)              row_d = '0;
    else if (ld_fire | rd_fire) row_d = row_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          unique case (host.cmd_op)
            2'b00:   state_d = S_LOAD;
            2'b01:   state_d = (host.cmd_gens != '0) ? S_RUN : S_FIN;
            2'b10:   state_d = S_RD_ADDR;
            default: state_d = S_FIN;
          endcase
        end
      end
      // Completion keys off the registered row-15 write, not the counter wrapping to 0.
      S_LOAD:    if (arr_write_enb_q && arr_vali_selector_q == LAST_ROW) state_d = S_FIN;
      S_RUN:     state_d = S_RUN_GAP;
      S_RUN_GAP: state_d = (gen_q != '0) ? S_RUN : S_FIN;
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_RD_HOLD;
      S_RD_HOLD: if (rd_fire) state_d = (row_q == LAST_ROW) ? S_FIN : S_RD_ADDR;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // cmd_ready is gated by reset so that every output reads 0 while reset is held.
    host.cmd_ready = reset & (state_q == S_IDLE);
    host.busy      = (state_q != S_IDLE);
    host.ld_ready  = (state_q == S_LOAD) & ~arr_write_enb_q;
    host.rd_valid  = (state_q == S_RD_HOLD);
    host.done      = (state_q == S_FIN);
    host.cmd_err   = (state_q == S_FIN) & err_q;
    host.rd_data   = rd_data_q;
    host.rd_row    = row_q;
  end

  // Array-side registers are loaded from next-state decisions so pulses line up with the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_vali_q          <= '0;
      arr_vali_selector_q <= '0;
      arr_write_enb_q     <= 1'b0;
      arr_step_q          <= 1'b0;
      arr_valo_selector_q <= '0;
      rd_data_q           <= '0;
      gen_q               <= '0;
      err_q               <= 1'b0;
    end else begin
      arr_write_enb_q <= ld_fire;
      arr_step_q      <= (state_d == S_RUN);
      if (ld_fire) begin
        arr_vali_q          <= host.ld_data;
        arr_vali_selector_q <= row_q;
      end
      if (state_d == S_RD_ADDR) arr_valo_selector_q <= row_d;
      // Selector is valid in RD_ADDR, so the array's registered output is ready during RD_WAIT.
      if (state_q == S_RD_WAIT) rd_data_q <= arr_valo;
      if (cmd_fire) begin
        gen_q <= host.cmd_gens;
        err_q <= (host.cmd_op == 2'b11);
      end else if (state_q == S_RUN) begin
        gen_q <= gen_q - GEN_W'(1);
      end
    end
  end

  assign arr_vali          = arr_vali_q;
  assign arr_vali_selector = arr_vali_selector_q;
  assign arr_write_enb     = arr_write_enb_q;
  assign arr_step          = arr_step_q;
  assign arr_valo_selector = arr_valo_selector_q;

endmodule

// File: tb/tb_life_array_sequencer.sv
// Directed bench for life_array_sequencer: a command table with hand-computed results,
// plus hand-written reset sequences. The array is modelled as valo <= 16'hA500 | selector.
module tb_life_array_sequencer;
  localparam int WIDTH = 16;
  localparam int GEN_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  life_array_sequencer_if #(.WIDTH(WIDTH), .GEN_W(GEN_W)) host ();

  logic [WIDTH-1:0] arr_vali, arr_valo;
  logic [3:0]       arr_vali_selector, arr_valo_selector;
  logic             arr_write_enb, arr_step;

  life_array_sequencer #(.ROWS(16), .WIDTH(WIDTH), .GEN_W(GEN_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .host              (host),
    .arr_vali          (arr_vali),
    .arr_vali_selector (arr_vali_selector),
    .arr_write_enb     (arr_write_enb),
    .arr_step          (arr_step),
    .arr_valo_selector (arr_valo_selector),
    .arr_valo          (arr_valo)
  );

  always @(posedge clk) arr_valo <= 16'hA500 | {12'h000, arr_valo_selector};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ld_pattern(input int mode, input int r);
    return (mode == 1) ? (16'h0001 << r) : (16'h5A00 | 16'(r));
  endfunction

  // Results of the most recent command, measured in cycles after the accept cycle.
  int r_done_cyc, r_steps, r_first_step, r_gap_bad, r_writes, r_wr_bad, r_last_wr;
  int r_rows, r_rd_bad, r_first_rd, r_last_hs, r_stalls, r_both;
  bit r_done, r_err;

  // ld_mode: 0 none, 1 ld_valid held high, 2 ld_valid random. Dump stalls stall_len cycles on row 7.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] gens, input int ld_mode,
                         input int stall_len, input int budget);
    int ld_idx, wait_cnt, stall_cnt, last_step;
    r_done_cyc = 0; r_steps = 0; r_first_step = 0; r_gap_bad = 0; r_writes = 0;
    r_wr_bad = 0; r_last_wr = 0; r_rows = 0; r_rd_bad = 0; r_first_rd = 0;
    r_last_hs = 0; r_stalls = 0; r_both = 0; r_done = 0; r_err = 0;
    ld_idx = 0; wait_cnt = 0; stall_cnt = 0; last_step = 0;
    @(negedge clk);
    while (!host.cmd_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_gens  = gens;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      host.cmd_valid = 1'b0;
      if (arr_write_enb && arr_step) r_both++;
      if (arr_write_enb) begin
        if (arr_vali_selector != 4'(r_writes) || arr_vali != ld_pattern(ld_mode, r_writes)) r_wr_bad++;
        r_writes++;
        r_last_wr = cyc;
      end
      if (arr_step) begin
        if (r_steps == 0) r_first_step = cyc;
        else if (cyc - last_step != 2) r_gap_bad++;
        last_step = cyc;
        r_steps++;
      end
      if (host.rd_valid) begin
        if (r_first_rd == 0) r_first_rd = cyc;
        if (host.rd_row != 4'(r_rows) || host.rd_data != (16'hA500 | 16'(r_rows))) r_rd_bad++;
      end
      if (host.done) begin
        r_done = 1'b1;
        r_done_cyc = cyc;
        r_err = host.cmd_err;
        break;
      end
      if (ld_mode != 0) begin
        host.ld_valid = (ld_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        host.ld_data  = ld_pattern(ld_mode, ld_idx);
        if (host.ld_valid && host.ld_ready) ld_idx++;
      end
      if (op == 2'b10) begin
        host.rd_ready = 1'b1;
        if (host.rd_valid && r_rows == 7 && stall_cnt < stall_len) begin
          host.rd_ready = 1'b0;
          stall_cnt++;
        end
        if (host.rd_valid && host.rd_ready) begin
          r_last_hs = cyc;
          r_rows++;
        end
      end
    end
    host.ld_valid = 1'b0;
    host.rd_ready = 1'b0;
    r_stalls = stall_cnt;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] gens;
    int         ld_mode;
    int         stall_len;
    int         exp_lat;    // 0: latency is data-dependent and checked relationally
    int         exp_steps;
    int         exp_writes;
    int         exp_rows;
    bit         exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //          op     gens   ld stl  lat  steps wr  rows err
    vecs[0] = '{2'b00, 8'd0,   1, 0,  33,  0,    16, 0,   0};  // LOAD full rate
    vecs[1] = '{2'b01, 8'd3,   0, 0,  7,   3,    0,  0,   0};  // RUN 3
    vecs[2] = '{2'b01, 8'd0,   0, 0,  1,   0,    0,  0,   0};  // RUN 0
    vecs[3] = '{2'b11, 8'd0,   0, 0,  1,   0,    0,  0,   1};  // reserved op
    vecs[4] = '{2'b00, 8'd0,   1, 0,  33,  0,    16, 0,   0};  // LOAD right after reserved op
    vecs[5] = '{2'b00, 8'd0,   2, 0,  0,   0,    16, 0,   0};  // LOAD throttled
    vecs[6] = '{2'b10, 8'd0,   0, 0,  0,   0,    0,  16,  0};  // DUMP, rd_ready high
    vecs[7] = '{2'b10, 8'd0,   0, 5,  0,   0,    0,  16,  0};  // DUMP, stall on row 7
    vecs[8] = '{2'b01, 8'hFF,  0, 0,  511, 255,  0,  0,   0};  // RUN 255

    host.cmd_valid = 1'b0; host.cmd_op = 2'b00; host.cmd_gens = '0;
    host.ld_valid  = 1'b0; host.ld_data = '0;   host.rd_ready = 1'b0;

    // Reset held: every output is 0.
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {arr_step, arr_write_enb, arr_valo_selector, arr_vali_selector, arr_vali,
           host.cmd_ready, host.busy, host.done, host.cmd_err, host.ld_ready,
           host.rd_valid, host.rd_data, host.rd_row}, 0);
    reset = 1'b1;
    #1;
    check("ready_after_release", host.cmd_ready, 1);
    check("idle_after_release", host.busy, 0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].gens, vecs[i].ld_mode, vecs[i].stall_len, 600);
      check($sformatf("v%0d_done_seen", i), r_done, 1);
      check($sformatf("v%0d_steps", i), r_steps, vecs[i].exp_steps);
      check($sformatf("v%0d_writes", i), r_writes, vecs[i].exp_writes);
      check($sformatf("v%0d_rows", i), r_rows, vecs[i].exp_rows);
      check($sformatf("v%0d_cmd_err", i), r_err, vecs[i].exp_err);
      check($sformatf("v%0d_write_and_step", i), r_both, 0);
      check($sformatf("v%0d_step_spacing", i), r_gap_bad, 0);
      check($sformatf("v%0d_write_order", i), r_wr_bad, 0);
      check($sformatf("v%0d_dump_data", i), r_rd_bad, 0);
      if (vecs[i].exp_lat != 0)   check($sformatf("v%0d_done_latency", i), r_done_cyc, vecs[i].exp_lat);
      if (vecs[i].exp_steps != 0) check($sformatf("v%0d_first_step", i), r_first_step, 1);
      if (vecs[i].op == 2'b00)    check($sformatf("v%0d_done_after_last_write", i), r_done_cyc, r_last_wr + 1);
      if (vecs[i].op == 2'b10) begin
        check($sformatf("v%0d_first_rd_valid", i), r_first_rd, 3);
        check($sformatf("v%0d_done_after_last_rd", i), r_done_cyc, r_last_hs + 1);
        check($sformatf("v%0d_stall_cycles", i), r_stalls, vecs[i].stall_len);
      end
    end

    // Reset in the middle of RUN 5: outputs drop at once and no done follows.
    begin
      int t, n_done, n_step;
      @(negedge clk);
      host.cmd_valid = 1'b1; host.cmd_op = 2'b01; host.cmd_gens = 8'd5;
      t = 0;
      do begin
        @(negedge clk);
        host.cmd_valid = 1'b0;
        t++;
      end while (!arr_step && t < 20);
      check("mid_run_step_seen", arr_step, 1);
      repeat (2) @(negedge clk);
      check("mid_run_step_high", arr_step, 1);
      reset = 1'b0;
      #1;
      check("mid_run_reset_outputs_zero",
            {arr_step, arr_write_enb, arr_valo_selector, arr_vali_selector, arr_vali,
             host.cmd_ready, host.busy, host.done, host.cmd_err, host.ld_ready,
             host.rd_valid, host.rd_data, host.rd_row}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_run_ready_after_release", host.cmd_ready, 1);
      check("mid_run_idle_after_release", host.busy, 0);
      n_done = 0; n_step = 0;
      repeat (12) begin
        @(negedge clk);
        if (host.done) n_done++;
        if (arr_step) n_step++;
      end
      check("mid_run_no_done", n_done, 0);
      check("mid_run_no_step", n_step, 0);
    end

    // Normal RUN 2 after the abandoned command.
    run_cmd(2'b01, 8'd2, 0, 0, 100);
    check("post_reset_run_latency", r_done_cyc, 5);
    check("post_reset_run_steps", r_steps, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
